range_ui: RTL
=============

# range_ui

Pushbutton and switch front end that drives the Collatz range engine and selects which result is shown. Debounces the four active-low KEY inputs and turns presses into single-cycle events. Issues the `go`/`start` launch to the range engine, waits for `done`, then lets the user step a result index `n` through the computed range. Supplies the start-plus-offset value to the hex display path.

## Interface
- `RAM_WORDS`, default 256: number of results held by the range engine; `n` spans 0..RAM_WORDS-1.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key change is accepted (10 ms at 50 MHz).
- `REPEAT_DELAY`, default 25000000: hold time before auto-repeat starts on step keys (0.5 s).
- `REPEAT_PERIOD`, default 5000000: auto-repeat interval (0.1 s).

Ports:
- `clk`  in  1  system clock, CLOCK_50; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `KEY`  in  4  raw pushbuttons, active-low, asynchronous.
- `SW`  in  10  raw switches, start value.
- `done`  in  1  range engine finished, level, sampled high.
- `go`  out  1  one-cycle launch pulse to range engine.
- `start`  out  32  launch start value, zero-extended SW, held stable.
- `n`  out  12  result index into range engine RAM.
- `disp_val`  out  12  start + n, truncated to 12 bits, for hex display.
- `busy`  out  1  high from `go` until `done` observed.

## Operation
- Per key: 2-flop synchronizer, then debouncer. Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Press event: debounced 1->0 transition, one cycle wide. Releases generate nothing.
- Key map:
  - KEY[3] = run.
  - KEY[0] = n+1.
  - KEY[1] = n-1.
  - KEY[2] = n to 0.
- Auto-repeat applies to KEY[0] and KEY[1] only. While held, first repeat fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles.
- FSM states:
  - IDLE: reset state; no valid results. Run press -> LAUNCH. Step keys ignored.
  - LAUNCH: exactly one cycle. `go`=1, `start` latched from SW, n cleared to 0. Next state BUSY.
  - BUSY: `busy`=1. All key events ignored, including run. `done`=1 -> VIEW.
  - VIEW: step keys act on n. Run press -> LAUNCH.
- n saturates:
  - +1 at RAM_WORDS-1 holds.
  - -1 at 0 holds.
  - Reset-to-0 always permitted in VIEW.
- Simultaneous events in one cycle: priority run > reset-to-0 > +1 > -1. Only one acts.
- `disp_val` = start[11:0] + n, modulo 2^12.
- `start` changes only in LAUNCH. SW movement at other times has no effect on outputs.

## Timing
- Reset values:
  - State IDLE.
  - `go`=0, `busy`=0.
  - `start`=0, `n`=0, `disp_val`=0.
  - Synchronizers and debounced levels = 1 (released).
  - Debounce and repeat counters = 0.
- Key latency: a clean press at cycle t gives its event at t+2+DEBOUNCE_CYCLES. The action registers one cycle later.
- `go` is registered and high for exactly one cycle. `busy` rises the same cycle as `go` and falls the cycle after `done` is sampled high.
- `done` high in LAUNCH is ignored. Only BUSY samples it.
- Reset mid-BUSY returns to IDLE with no `go`. A held key must be released and re-pressed to act.
- All outputs are registered; none is combinational from inputs.

## Structure
- Shared package `range_ui_pkg`:
  - state enum `ui_state_t` (IDLE, LAUNCH, BUSY, VIEW).
  - key index constants KEY_STEP_UP=0, KEY_STEP_DN=1, KEY_ZERO=2, KEY_RUN=3.
- Sub-module `debounce`: synchronizer, counter and press-event output. Instantiated four times with parameter DEBOUNCE_CYCLES.
- Auto-repeat counters and FSM live in `range_ui`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, RAM_WORDS=256.
- Reset, then SW=10'h01B and a clean KEY[3] press -> exactly one `go` cycle. `start`=32'h1B, `n`=0, `busy`=1 until `done` pulses. Then `disp_val`=12'h01B.
- KEY[3] bouncing (toggles every 2 cycles for 10 cycles, then held low) -> exactly one `go`.
- In VIEW, press KEY[0] three times -> `n`=3, `disp_val`=start+3. KEY[1] four times -> `n`=0, saturated.
- Hold KEY[0] for 40 cycles after the event -> `n` = 1 + 1 + 4 = 6. Event at hold start, repeats at 20, 25, 30, 35, 40.
- During BUSY, press KEY[0] and KEY[3] -> no `go`, `n` unchanged. Same-cycle KEY[2] and KEY[0] events in VIEW with `n`=5 -> `n`=0.
- Assert `reset` mid-BUSY -> all outputs return to reset values next cycle. `done` arriving afterwards is ignored and the state stays IDLE.

Source files
------------

// File: rtl/range_ui_pkg.sv
// Shared types and constants for the pushbutton/switch front end of the range engine.
package range_ui_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    VIEW
  } ui_state_t;

  localparam int unsigned NUM_KEYS    = 4;
  localparam int unsigned KEY_STEP_UP = 0;
  localparam int unsigned KEY_STEP_DN = 1;
  localparam int unsigned KEY_ZERO    = 2;
  localparam int unsigned KEY_RUN     = 3;

  localparam int unsigned SW_W    = 10;
  localparam int unsigned START_W = 32;
  localparam int unsigned N_W     = 12;

  // Keys that auto-repeat while held
  localparam logic [NUM_KEYS-1:0] REPEAT_KEYS =
    NUM_KEYS'((1 << KEY_STEP_UP) | (1 << KEY_STEP_DN));

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer and debouncer for one active-low key; emits a one-cycle press event.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [1:0]       warm;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // A key already held when reset releases must be seen released before it can press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      press <= 1'b0;
      if (warm[1] && sync2) begin
        armed <= 1'b1;
      end
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= level & armed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/range_ui.sv
// Key/switch front end: launches the range engine, waits for done, then steps the result index n.
module range_ui
  import range_ui_pkg::*;
#(
  parameter int unsigned RAM_WORDS       = 256,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [SW_W-1:0]     SW,
  input  logic                done,
  output logic                go,
  output logic [START_W-1:0]  start,
  output logic [N_W-1:0]      n,
  output logic [N_W-1:0]      disp_val,
  output logic                busy
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);
  localparam logic [N_W-1:0]   N_MAX   = N_W'(RAM_WORDS - 1);

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] rpt_fire;
  logic [NUM_KEYS-1:0] key_ev;

  ui_state_t state;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_active;
    logic             rpt_fast;

    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_raw(KEY[g]),
      .level  (key_level[g]),
      .press  (key_press[g])
    );

    // rpt_cnt counts cycles since the press event or the last repeat
    assign rpt_fire[g] = rpt_active && !key_level[g] &&
                         (rpt_cnt == (rpt_fast ? RPT_PER : RPT_DLY));
    assign key_ev[g]   = key_press[g] | (rpt_fire[g] & REPEAT_KEYS[g]);

    always_ff @(posedge clk) begin
      if (reset || key_level[g]) begin
        rpt_cnt    <= '0;
        rpt_active <= 1'b0;
        rpt_fast   <= 1'b0;
      end else if (key_press[g]) begin
        rpt_cnt    <= RPT_W'(1);
        rpt_active <= 1'b1;
        rpt_fast   <= 1'b0;
      end else if (rpt_fire[g]) begin
        rpt_cnt  <= RPT_W'(1);
        rpt_fast <= 1'b1;
      end else if (rpt_active) begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end

  // Launch/busy/view sequencing; run beats zero beats up beats down
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      go    <= 1'b0;
      busy  <= 1'b0;
      start <= '0;
      n     <= '0;
    end else begin
      go <= 1'b0;
      case (state)
        IDLE, VIEW: begin
          if (key_ev[KEY_RUN]) begin
            state <= LAUNCH;
            go    <= 1'b1;
            busy  <= 1'b1;
            start <= START_W'(SW);
            n     <= '0;
          end else if (state == VIEW) begin
            if (key_ev[KEY_ZERO]) begin
              n <= '0;
            end else if (key_ev[KEY_STEP_UP]) begin
              if (n != N_MAX) n <= n + N_W'(1);
            end else if (key_ev[KEY_STEP_DN]) begin
              if (n != '0) n <= n - N_W'(1);
            end
          end
        end
        LAUNCH: state <= BUSY;
        BUSY: begin
          if (done) begin
            state <= VIEW;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_val <= '0;
    end else begin
      disp_val <= start[N_W-1:0] + n;
    end
  end

endmodule
